fetch_stage: RTL and testbench

//  Instruction-fetch stage that sits directly upstream of InstructionMem.
//  - Owns the program counter and drives InstructionMem's 30-bit word address.
//  - Captures the returned instruction into the IF/ID pipeline register for decode.
//  - Handles decode back-pressure, branch/jump redirects and misaligned redirect targets.

---
 rtl/fetch_stage_pkg.sv | 14 +
 rtl/fetch_stage_if_id_reg.sv | 40 ++++
 rtl/fetch_stage.sv | 97 +++++++++
 tb/tb_fetch_stage.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode constants and the IF/ID register layout consumed by decode.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instruction;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush wins over load; reset and flush give an empty NOP slot.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t q_q;
    if_id_t q_d;
    if_id_t empty_slot;

    always_comb begin
        empty_slot             = '0;
        empty_slot.instruction = NOP_WORD;
        q_d                    = q_q;
        if (flush) begin
            q_d = empty_slot;
        end else if (load) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= empty_slot;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the word PC, drives InstructionMem and fills the IF/ID register,
// honouring decode back-pressure, redirects and misaligned-target faults.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = fetch_stage_pkg::RESET_VECTOR,
    parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic [29:0] imem_pc,
    input  logic [31:0] imem_instruction,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instruction,
    output logic        fetch_fault,
    output logic [31:0] fetch_fault_pc
);
    import fetch_stage_pkg::*;

    logic [29:0] pc_q, pc_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic        advance;
    logic        load;
    logic        flush;
    logic [29:0] pc_inc;
    if_id_t      if_id_d;
    if_id_t      if_id_q;

    assign advance = !if_id_q.valid || id_ready;
    assign pc_inc  = pc_q + 30'd1;

    always_comb begin
        pc_d       = pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        load       = 1'b0;
        flush      = 1'b0;

        if_id_d.valid       = 1'b1;
        if_id_d.pc          = {pc_q, 2'b00};
        if_id_d.pc_plus4    = {pc_inc, 2'b00};
        if_id_d.instruction = imem_instruction;

        // A redirect always flushes, even against a stalled decode, leaving one bubble.
        if (redirect_valid) begin
            pc_d  = redirect_pc[31:2];
            flush = 1'b1;
            if (redirect_pc[1:0] != 2'b00) begin
                fault_d    = 1'b1;
                fault_pc_d = redirect_pc;
            end else begin
                fault_d = 1'b0;
            end
        end else if (fault_q) begin
            flush = 1'b1;
        end else if (advance) begin
            load = 1'b1;
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC[31:2];
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0;
        end else begin
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    if_id_reg #(
        .NOP_WORD(NOP_INSTR)
    ) u_if_id_reg (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .flush(flush),
        .d    (if_id_d),
        .q    (if_id_q)
    );

    assign imem_pc           = pc_q;
    assign if_id_valid       = if_id_q.valid;
    assign if_id_pc          = if_id_q.pc;
    assign if_id_pc_plus4    = if_id_q.pc_plus4;
    assign if_id_instruction = if_id_q.instruction;
    assign fetch_fault       = fault_q;
    assign fetch_fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; the memory model returns the word index as the instruction.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [29:0] imem_pc;
    logic [31:0] imem_instruction;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instruction;
    logic        fetch_fault;
    logic [31:0] fetch_fault_pc;

    int n_compared;
    int n_failed;

    fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .imem_pc          (imem_pc),
        .imem_instruction (imem_instruction),
        .id_ready         (id_ready),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .if_id_valid      (if_id_valid),
        .if_id_pc         (if_id_pc),
        .if_id_pc_plus4   (if_id_pc_plus4),
        .if_id_instruction(if_id_instruction),
        .fetch_fault      (fetch_fault),
        .fetch_fault_pc   (fetch_fault_pc)
    );

    assign imem_instruction = {2'b00, imem_pc};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] e_imem;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_instr;
        logic        e_fault;
        logic [31:0] e_fpc;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        reset          = rst;
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc,
                                input logic [31:0] e_imem, input logic e_valid, input logic [31:0] e_pc,
                                input logic [31:0] e_pc4, input logic [31:0] e_instr, input logic e_fault,
                                input logic [31:0] e_fpc);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.e_imem = e_imem; v.e_valid = e_valid; v.e_pc = e_pc; v.e_pc4 = e_pc4;
        v.e_instr = e_instr; v.e_fault = e_fault; v.e_fpc = e_fpc;
        return v;
    endfunction

    initial begin
        int waited;
        n_compared     = 0;
        n_failed       = 0;
        reset          = 1'b1;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        //               rst rdy rv rpc           imem         v  pc            pc4           instr         f  fpc
        vecs[0]  = mk(1, 1, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        32'h13,       0, 32'h0);
        vecs[1]  = mk(0, 1, 0, 32'h0,        32'h1,        1, 32'h0,        32'h4,        32'h0,        0, 32'h0);
        vecs[2]  = mk(0, 1, 0, 32'h0,        32'h2,        1, 32'h4,        32'h8,        32'h1,        0, 32'h0);
        vecs[3]  = mk(0, 1, 0, 32'h0,        32'h3,        1, 32'h8,        32'hC,        32'h2,        0, 32'h0);
        vecs[4]  = mk(0, 0, 0, 32'h0,        32'h3,        1, 32'h8,        32'hC,        32'h2,        0, 32'h0);
        vecs[5]  = mk(0, 0, 0, 32'h0,        32'h3,        1, 32'h8,        32'hC,        32'h2,        0, 32'h0);
        vecs[6]  = mk(0, 0, 0, 32'h0,        32'h3,        1, 32'h8,        32'hC,        32'h2,        0, 32'h0);
        vecs[7]  = mk(0, 1, 0, 32'h0,        32'h4,        1, 32'hC,        32'h10,       32'h3,        0, 32'h0);
        vecs[8]  = mk(0, 0, 1, 32'h40,       32'h10,       0, 32'h0,        32'h0,        32'h13,       0, 32'h0);
        vecs[9]  = mk(0, 0, 0, 32'h0,        32'h11,       1, 32'h40,       32'h44,       32'h10,       0, 32'h0);
        vecs[10] = mk(0, 1, 1, 32'h42,       32'h10,       0, 32'h0,        32'h0,        32'h13,       1, 32'h42);
        vecs[11] = mk(0, 1, 0, 32'h0,        32'h10,       0, 32'h0,        32'h0,        32'h13,       1, 32'h42);
        vecs[12] = mk(0, 1, 0, 32'h0,        32'h10,       0, 32'h0,        32'h0,        32'h13,       1, 32'h42);
        vecs[13] = mk(0, 1, 1, 32'h80,       32'h20,       0, 32'h0,        32'h0,        32'h13,       0, 32'h42);
        vecs[14] = mk(0, 1, 0, 32'h0,        32'h21,       1, 32'h80,       32'h84,       32'h20,       0, 32'h42);
        vecs[15] = mk(0, 1, 1, 32'hFFFFFFFC, 32'h3FFFFFFF, 0, 32'h0,        32'h0,        32'h13,       0, 32'h42);
        vecs[16] = mk(0, 1, 0, 32'h0,        32'h0,        1, 32'hFFFFFFFC, 32'h0,        32'h3FFFFFFF, 0, 32'h42);
        vecs[17] = mk(0, 1, 0, 32'h0,        32'h1,        1, 32'h0,        32'h4,        32'h0,        0, 32'h42);
        vecs[18] = mk(0, 0, 0, 32'h0,        32'h1,        1, 32'h0,        32'h4,        32'h0,        0, 32'h42);
        vecs[19] = mk(1, 0, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        32'h13,       0, 32'h0);
        vecs[20] = mk(1, 1, 1, 32'h42,       32'h0,        0, 32'h0,        32'h0,        32'h13,       0, 32'h0);
        vecs[21] = mk(0, 1, 0, 32'h0,        32'h1,        1, 32'h0,        32'h4,        32'h0,        0, 32'h0);

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
            check("imem_pc",        i, {2'b00, imem_pc},          vecs[i].e_imem);
            check("if_id_valid",    i, {31'h0, if_id_valid},      {31'h0, vecs[i].e_valid});
            check("if_id_pc",       i, if_id_pc,                  vecs[i].e_pc);
            check("if_id_pc_plus4", i, if_id_pc_plus4,            vecs[i].e_pc4);
            check("if_id_instr",    i, if_id_instruction,         vecs[i].e_instr);
            check("fetch_fault",    i, {31'h0, fetch_fault},      {31'h0, vecs[i].e_fault});
            check("fetch_fault_pc", i, fetch_fault_pc,            vecs[i].e_fpc);
        end

        // Misaligned redirect while decode stalls, then an aligned redirect also under stall.
        drive(0, 1, 0, 32'h0);
        drive(0, 0, 1, 32'h103);
        check("seq_fault_set",   100, {31'h0, fetch_fault}, 32'h1);
        check("seq_fault_pc",    100, fetch_fault_pc, 32'h103);
        check("seq_fault_imem",  100, {2'b00, imem_pc}, 32'h40);
        drive(0, 0, 1, 32'h200);
        check("seq_fault_clear", 101, {31'h0, fetch_fault}, 32'h0);
        check("seq_bubble",      101, {31'h0, if_id_valid}, 32'h0);

        // Fetch must resume on its own within a bounded number of cycles.
        waited = 0;
        while (!if_id_valid && waited < 5) begin
            drive(0, 0, 0, 32'h0);
            waited++;
        end
        check("seq_resume_valid", 102, {31'h0, if_id_valid}, 32'h1);
        check("seq_resume_pc",    102, if_id_pc, 32'h200);
        check("seq_resume_instr", 102, if_id_instruction, 32'h80);
        drive(0, 0, 0, 32'h0);
        check("seq_stall_pc",     103, if_id_pc, 32'h200);
        check("seq_stall_imem",   103, {2'b00, imem_pc}, 32'h81);
        drive(0, 1, 0, 32'h0);
        check("seq_release_pc",   104, if_id_pc, 32'h204);
        check("seq_release_pc4",  104, if_id_pc_plus4, 32'h208);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
